// File: rtl/vector_mem_read_ctrl.sv
// vector_mem_read_ctrl: strided row-read sequencer draining vector_memory into a 2-entry valid/ready FIFO
// Optional feature macro: VEC_RD_LANE_MASK_EN (adds lane_mask, a per-lane read enable captured on start)
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   start, base_addr, stride, num_rows  command; sampled only in IDLE
//   busy, done                          command in progress / one-cycle completion pulse
//   mem_read_req, mem_read_addr         registered per-bank read strobes and addresses
//   mem_read_data                       bank outputs for the previous cycle's request
//   out_valid, out_ready, out_data      output row stream (lane order as mem_read_data)
//   lane_mask                           (VEC_RD_LANE_MASK_EN only) lanes to read; others return 0
module vector_mem_read_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_ELEM   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH-1:0]            stride,
    input  logic [ADDR_WIDTH-1:0]            num_rows,
`ifdef VEC_RD_LANE_MASK_EN
    input  logic [NUM_ELEM-1:0]              lane_mask,
`endif
    output logic                             busy,
    output logic                             done,
    output logic [NUM_ELEM-1:0]              mem_read_req,
    output logic [ADDR_WIDTH*NUM_ELEM-1:0]   mem_read_addr,
    input  logic [DATA_WIDTH*NUM_ELEM-1:0]   mem_read_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*NUM_ELEM-1:0]   out_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr, stride_r, remaining, issue_addr;
    logic [DATA_WIDTH*NUM_ELEM-1:0] tail, row_in;
    logic [NUM_ELEM-1:0] mask_r, issue_mask;
    logic [1:0] count;
    logic inflight, pop, push, launch, credit_ok, issue;

`ifdef VEC_RD_LANE_MASK_EN
    always_ff @(posedge clk) begin
        if (reset)
            mask_r <= '0;
        else if (launch)
            mask_r <= lane_mask;
    end
    // The first read goes out on the accepting edge, before mask_r holds the new mask.
    assign issue_mask = (state == IDLE) ? lane_mask : mask_r;
`else
    assign mask_r     = '1;
    assign issue_mask = '1;
`endif

    for (genvar g = 0; g < NUM_ELEM; g++) begin : g_lane
        assign row_in[g*DATA_WIDTH +: DATA_WIDTH] = mask_r[g] ? mem_read_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign out_valid = count != 2'd0;
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    assign launch    = (state == IDLE) & start;
    // Buffered rows plus the row still coming back from memory must leave room for one more.
    assign credit_ok = ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    // The first read is launched on the accepting edge so the request appears one cycle after start.
    assign issue      = launch ? (num_rows != '0) : (state == ISSUE) && (remaining != '0) && credit_ok;
    assign issue_addr = launch ? base_addr : cur_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr      <= '0;
            stride_r      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            mem_read_req  <= '0;
            mem_read_addr <= '0;
        end else begin
            inflight     <= issue;
            mem_read_req <= issue ? issue_mask : '0;
            remaining    <= (launch ? num_rows : remaining) - {{(ADDR_WIDTH-1){1'b0}}, issue};
            if (launch)
                stride_r <= stride;
            if (issue) begin
                mem_read_addr <= {NUM_ELEM{issue_addr}};
                cur_addr      <= issue_addr + (launch ? stride : stride_r);
            end
        end
    end

    // out_data is the FIFO head; tail holds the second row when two are buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            out_data <= '0;
            tail     <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && count == 2'd2)
                out_data <= tail;
            else if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                out_data <= row_in;
            if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
                tail <= row_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_rows == '0) ? FIN : ISSUE;
            ISSUE: if (remaining == '0) state_nxt = DRAIN;
            // Leave on the edge that accepts the final row so done follows that handshake directly.
            DRAIN: if (!inflight && (count == 2'd0 || (count == 2'd1 && pop))) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ISSUE) || (state == DRAIN);
        done = state == FIN;
    end
endmodule

// File: tb/tb_vector_mem_read_ctrl.sv
// tb_vector_mem_read_ctrl: directed self-checking bench for vector_mem_read_ctrl
module tb_vector_mem_read_ctrl;
    localparam int DW = 10;
    localparam int AW = 12;
    localparam int NE = 16;
    logic clk = 1'b0;
    logic reset, start, out_ready, busy, done, out_valid, held;
    logic [AW-1:0] base_addr, stride, num_rows;
    logic [NE-1:0] mem_read_req;
    logic [AW*NE-1:0] mem_read_addr;
    logic [DW*NE-1:0] mem_read_data, out_data, held_data;
    logic [3:0] pat;
    int total = 0, fails = 0, got, issued, maxbuf;
`ifdef VEC_RD_LANE_MASK_EN
    logic [NE-1:0] lane_mask;
`endif

    always #5 clk = ~clk;

    vector_mem_read_ctrl dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .stride(stride),
        .num_rows(num_rows),
`ifdef VEC_RD_LANE_MASK_EN
        .lane_mask(lane_mask),
`endif
        .busy(busy),
        .done(done),
        .mem_read_req(mem_read_req),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    // Memory model: each lane returns a value derived from its own address and lane number.
    always_comb begin
        mem_read_data = '0;
        for (int g = 0; g < NE; g++)
            mem_read_data[g*DW +: DW] = mem_read_addr[g*AW +: DW] ^ 10'(g * 61);
    end

    function automatic logic [DW*NE-1:0] mrow(input logic [AW-1:0] a, input logic [NE-1:0] m);
        logic [DW*NE-1:0] r;
        r = '0;
        for (int g = 0; g < NE; g++)
            r[g*DW +: DW] = m[g] ? (a[DW-1:0] ^ 10'(g * 61)) : 10'd0;
        return r;
    endfunction

    function automatic logic [AW*NE-1:0] bc(input logic [AW-1:0] a);
        return {NE{a}};
    endfunction

    task automatic chk(input string tag, input logic [AW*NE-1:0] obs, input logic [AW*NE-1:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; stride = '0; num_rows = '0;
`ifdef VEC_RD_LANE_MASK_EN
        lane_mask = '1;
`endif
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_read_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0;
        tick;

        // Unit stride, 4 rows, consumer always ready
        base_addr = 12'h010; stride = 12'd1; num_rows = 12'd4; start = 1'b1; out_ready = 1'b1;
        chk("t1_idle_busy", busy, 0);
        tick; start = 1'b0;
        chk("t1_req0", mem_read_req, 16'hFFFF);
        chk("t1_addr0", mem_read_addr, bc(12'h010));
        chk("t1_busy_c1", busy, 1);
        chk("t1_valid_c1", out_valid, 0);
        for (int k = 1; k < 4; k++) begin
            tick;
            chk($sformatf("t1_req%0d", k), mem_read_req, 16'hFFFF);
            chk($sformatf("t1_addr%0d", k), mem_read_addr, bc(12'(12'h010 + k)));
            chk($sformatf("t1_valid%0d", k), out_valid, 1);
            chk($sformatf("t1_row%0d", k - 1), out_data, mrow(12'(12'h010 + k - 1), '1));
        end
        tick;
        chk("t1_req_off", mem_read_req, 0);
        chk("t1_row3", {out_valid, out_data}, {1'b1, mrow(12'h013, '1)});
        chk("t1_busy_last", {busy, done}, 2'b10);
        tick;
        chk("t1_done", {busy, done, out_valid}, 3'b010);
        tick;
        chk("t1_done_once", done, 0);

        // Address wrap at the top of the 12-bit space
        base_addr = 12'hFFE; stride = 12'd3; num_rows = 12'd3; start = 1'b1;
        tick; start = 1'b0;
        chk("t2_addr0", mem_read_addr, bc(12'hFFE));
        tick;
        chk("t2_addr1", mem_read_addr, bc(12'h001));
        chk("t2_row0", out_data, mrow(12'hFFE, '1));
        tick;
        chk("t2_addr2", mem_read_addr, bc(12'h004));
        chk("t2_row1", out_data, mrow(12'h001, '1));
        tick;
        chk("t2_row2", {out_valid, out_data}, {1'b1, mrow(12'h004, '1)});
        tick;
        chk("t2_done", done, 1);
        tick;

        // Backpressure: out_ready follows 1,0,0,1 repeating
        base_addr = 12'h100; stride = 12'd2; num_rows = 12'd8; start = 1'b1; out_ready = 1'b1;
        pat = 4'b1001; got = 0; issued = 0; maxbuf = 0; held = 1'b0; held_data = '0;
        tick; start = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            if (mem_read_req != '0) issued++;
            if (issued - got > maxbuf) maxbuf = issued - got;
            out_ready = pat[cyc % 4];
            if (held)
                chk($sformatf("t3_stable%0d", cyc), {out_valid, out_data}, {1'b1, held_data});
            if (out_valid && out_ready) begin
                chk($sformatf("t3_row%0d", got), out_data, mrow(12'(12'h100 + 2 * got), '1));
                got++;
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            tick;
        end
        chk("t3_rows", got, 8);
        chk("t3_issued", issued, 8);
        chk("t3_maxbuf_le2", maxbuf <= 2, 1);
        chk("t3_done", {done, out_valid}, 2'b10);
        out_ready = 1'b1;
        tick;

        // Zero-row command
        num_rows = 12'd0; start = 1'b1;
        tick; start = 1'b0;
        chk("t4_done", {busy, done}, 2'b01);
        chk("t4_req", mem_read_req, 0);
        tick;
        chk("t4_after", {busy, done, out_valid}, 3'b000);
        chk("t4_req_after", mem_read_req, 0);

        // Reset in the middle of a 6-row command
        base_addr = 12'h200; stride = 12'd1; num_rows = 12'd6; start = 1'b1;
        tick; start = 1'b0;
        tick;
        chk("t5_row0", out_data, mrow(12'h200, '1));
        tick;
        chk("t5_row1", out_data, mrow(12'h201, '1));
        reset = 1'b1;
        tick;
        chk("t5_rst", {out_valid, busy, done}, 3'b000);
        chk("t5_rst_req", mem_read_req, 0);
        reset = 1'b0;
        tick;
        chk("t5_no_done", {done, out_valid, busy}, 3'b000);
        base_addr = 12'h300; stride = 12'd4; num_rows = 12'd2; start = 1'b1;
        tick; start = 1'b0;
        chk("t5_new_addr0", mem_read_addr, bc(12'h300));
        chk("t5_new_valid_c1", out_valid, 0);
        tick;
        chk("t5_new_row0", {out_valid, out_data}, {1'b1, mrow(12'h300, '1)});
        chk("t5_new_addr1", mem_read_addr, bc(12'h304));
        tick;
        chk("t5_new_row1", {out_valid, out_data}, {1'b1, mrow(12'h304, '1)});
        tick;
        chk("t5_new_done", {done, out_valid}, 2'b10);
        tick;

`ifdef VEC_RD_LANE_MASK_EN
        // Only lanes 0 and 2 enabled
        base_addr = 12'h050; stride = 12'd1; num_rows = 12'd2; lane_mask = 16'h0005; start = 1'b1;
        tick; start = 1'b0; lane_mask = '1;
        chk("t6_req0", mem_read_req, 16'h0005);
        tick;
        chk("t6_req1", mem_read_req, 16'h0005);
        chk("t6_row0", out_data, mrow(12'h050, 16'h0005));
        tick;
        chk("t6_req_off", mem_read_req, 0);
        chk("t6_row1", out_data, mrow(12'h051, 16'h0005));
        tick;
        chk("t6_done", done, 1);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/vector_mem_read_ctrl.md
Name: vector_mem_read_ctrl

Overview:
Strided read sequencer that sits directly downstream of vector_memory and drains it. On a start command it issues NUM_ELEM-wide row reads at base, base+stride, base+2*stride, and so on. All banks use the same address each cycle. Returned rows are buffered and presented on a valid/ready output stream to the SIMD/compute consumer, with full backpressure support and no data loss.

Parameters:
- DATA_WIDTH, 10, bits per lane element; must match the vector_memory instance.
- ADDR_WIDTH, 12, per-bank address width; also the width of stride and num_rows.
- NUM_ELEM, 16, lane/bank count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first row address; captured on accepted start.
- stride  in  ADDR_WIDTH  address increment per row; captured on accepted start.
- num_rows  in  ADDR_WIDTH  rows to read; captured on accepted start; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- mem_read_req  out  NUM_ELEM  per-bank read strobes to vector_memory.
- mem_read_addr  out  ADDR_WIDTH*NUM_ELEM  per-bank addresses; lane gv uses slice [gv*ADDR_WIDTH +: ADDR_WIDTH].
- mem_read_data  in  DATA_WIDTH*NUM_ELEM  bank outputs; valid exactly 1 cycle after the matching req.
- out_valid  out  1  output row valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_WIDTH*NUM_ELEM  output row; lane order identical to mem_read_data.

Behaviour:
- Reset, clk-synchronous: state=IDLE. busy, done, out_valid, and mem_read_req are all 0. out_data=0, FIFO empty, in-flight flag cleared.
- Reset mid-command aborts immediately. No done pulse is produced, and a row in flight from the memory is discarded.
- FSM states:
  - IDLE: start=1 captures base, stride, and num_rows, then goes to ISSUE. If num_rows=0, go instead to FIN.
  - ISSUE: issue reads until remaining=0, then go to DRAIN.
  - DRAIN: wait until the in-flight flag is clear, the FIFO is empty, and the last row has been accepted, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- start is ignored outside IDLE.
- busy=1 in ISSUE and DRAIN.
- Issue rule: issue in a cycle when state=ISSUE, remaining>0, and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready this cycle.
  - On issue, all mem_read_req bits are 1, all lanes carry cur_addr, remaining decrements, and cur_addr += stride modulo 2^ADDR_WIDTH (wrap, no error).
  - When not issuing, mem_read_req=0 and mem_read_addr holds its last value.
  - Issue outputs are registered.
- Capture: the cycle after an issue, mem_read_data is written into a 2-entry output FIFO. The credit rule above guarantees it never overflows.
- Output: out_valid = FIFO non-empty. out_data = FIFO head, registered, stable while out_valid=1 and out_ready=0. Pop on out_valid & out_ready.
- Simultaneous push and pop with the FIFO full or half-full is legal; the count is unchanged.
- Latency: start to first mem_read_req = 1 cycle. req to out_valid = 1 cycle (out_valid is 2 cycles after start).
- Throughput: with out_ready held at 1, one row per cycle sustained and no bubbles after the first.
- done is asserted the cycle after the handshake of the final row. With num_rows=0, done is asserted the cycle after start, with no memory reads.
- Row order on the output equals issue order.

Optional Feature:
VEC_RD_LANE_MASK_EN.
- Defined: adds input lane_mask[NUM_ELEM], captured on accepted start. Lane gv has mem_read_req bit gv = issue & lane_mask[gv]. Masked lanes are forced to 0 in the data written into the FIFO.
- Undefined: no lane_mask port; all lanes are always enabled.

Test Plan:
- base=0x010, stride=1, num_rows=4, out_ready=1 → reads at 0x010–0x013 on 4 consecutive cycles; 4 rows out back-to-back; out_valid first at start+2; done pulse once; busy high for exactly the command span.
- base=0xFFE, stride=3, num_rows=3 (ADDR_WIDTH=12) → addresses 0xFFE, 0x001, 0x004 (wrap verified); data matches preloaded memory.
- num_rows=8, out_ready toggled 1-0-0-1 pattern → at most 2 rows buffered, no row lost or duplicated, out_data stable during stall, done after 8th handshake.
- num_rows=0 → no mem_read_req ever; done=1 at start+1; busy stays 0.
- reset asserted mid-command (after 2 of 6 rows) → next cycle: out_valid=0, mem_read_req=0, IDLE; a new start runs cleanly with no stale rows.
- VEC_RD_LANE_MASK_EN defined, lane_mask=0x0005, num_rows=2 → only bits 0 and 2 of mem_read_req toggle; lanes other than 0 and 2 of out_data read 0.
